// File: rtl/divider_arbiter_pkg.sv
// rtl/divider_arbiter_pkg.sv - shared types and constants for the divider arbiter
package divider_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_LOAD,
        ST_WAIT,
        ST_DONE
    } state_e;

    localparam int OPW = 8;

    localparam logic [OPW-1:0]   DIVZ_QUOTIENT  = 8'hFF;
    localparam logic [2*OPW-1:0] TIMEOUT_RESULT = 16'h0000;

    // Divide-by-zero answer: saturated quotient, dividend passed through as remainder.
    function automatic logic [2*OPW-1:0] div0_result(input logic [OPW-1:0] dividend);
        return {DIVZ_QUOTIENT, dividend};
    endfunction

endpackage

// File: rtl/divider_arbiter_rr_arbiter.sv
// rtl/divider_arbiter_rr_arbiter.sv - round-robin grant search starting at ptr
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          valid
);

    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!valid && req[j]) begin
                grant[j] = 1'b1;
                idx      = IW'(j);
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/divider_arbiter.sv
// rtl/divider_arbiter.sv - shares one external divider among N_REQ requesters
module divider_arbiter
    import divider_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_i,
    input  logic [16*N_REQ-1:0]  values_i,
    output logic [N_REQ-1:0]     ack_o,
    output logic [15:0]          result_o,
    output logic                 err_o,
    output logic                 busy_o,
    output logic                 div_reset_n,
    output logic                 div_req,
    output logic [15:0]          div_values,
    input  logic                 div_ack,
    input  logic [15:0]          div_result
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [15:0]        div_values_q, div_values_d;
    logic [15:0]        result_q, result_d;
    logic               err_q, err_d;
    logic               div_req_q, div_req_d;
    logic               tmo_q, tmo_d;
    logic [7:0]         cnt_q, cnt_d;

    logic [N_REQ-1:0]   arb_grant;
    logic [IW-1:0]      arb_idx;
    logic               arb_valid;
    logic [15:0]        slice;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr_arbiter (
        .req   (req_i),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_comb begin
        slice = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (arb_grant[k]) begin
                slice = values_i[16*k +: 16];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        div_values_d = div_values_q;
        result_d     = result_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        ack_d        = '0;
        div_req_d    = 1'b0;
        tmo_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    gnt_d        = arb_grant;
                    ptr_d        = (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    div_values_d = slice;
                    if (slice[OPW-1:0] == '0) begin
                        state_d  = ST_DONE;
                        result_d = div0_result(slice[2*OPW-1:OPW]);
                        err_d    = 1'b1;
                        ack_d    = arb_grant;
                    end else begin
                        state_d   = ST_ISSUE;
                        div_req_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: state_d = ST_LOAD;
            ST_LOAD: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                if (div_ack) begin
                    state_d  = ST_DONE;
                    result_d = div_result;
                    err_d    = 1'b0;
                    ack_d    = gnt_q;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    // Last allowed WAIT cycle: abort and hold the divider in reset during DONE.
                    state_d  = ST_DONE;
                    result_d = TIMEOUT_RESULT;
                    err_d    = 1'b1;
                    ack_d    = gnt_q;
                    tmo_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            gnt_q        <= '0;
            ack_q        <= '0;
            div_values_q <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
            div_req_q    <= 1'b0;
            tmo_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            ack_q        <= ack_d;
            div_values_q <= div_values_d;
            result_q     <= result_d;
            err_q        <= err_d;
            div_req_q    <= div_req_d;
            tmo_q        <= tmo_d;
            cnt_q        <= cnt_d;
        end
    end

    assign ack_o       = ack_q;
    assign result_o    = result_q;
    assign err_o       = err_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign div_req     = div_req_q;
    assign div_values  = div_values_q;
    assign div_reset_n = ~reset & ~tmo_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// tb/tb_divider_arbiter.sv - directed self-checking bench for divider_arbiter
module tb_divider_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_i;
    logic [63:0] values_i;
    logic [3:0]  ack_o;
    logic [15:0] result_o;
    logic        err_o;
    logic        busy_o;
    logic        div_reset_n;
    logic        div_req;
    logic [15:0] div_values;
    logic        div_ack;
    logic [15:0] div_result;

    int tests = 0;
    int fails = 0;

    int  lat;
    bit  never_ack;
    int  dcnt;

    divider_arbiter #(.N_REQ(4), .TIMEOUT(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_i),
        .values_i    (values_i),
        .ack_o       (ack_o),
        .result_o    (result_o),
        .err_o       (err_o),
        .busy_o      (busy_o),
        .div_reset_n (div_reset_n),
        .div_req     (div_req),
        .div_values  (div_values),
        .div_ack     (div_ack),
        .div_result  (div_result)
    );

    always #5 clk = ~clk;

    // Divider model: acks lat+1 cycles after the cycle in which div_req is seen.
    always @(posedge clk) begin
        if (!div_reset_n) begin
            dcnt    <= 0;
            div_ack <= 1'b0;
        end else begin
            div_ack <= (dcnt == 1);
            if (div_req && !never_ack) dcnt <= lat;
            else if (dcnt != 0) dcnt <= dcnt - 1;
        end
    end

    assign div_result = (div_values[7:0] == 8'd0) ? 16'h0000 :
                        {div_values[15:8] / div_values[7:0], div_values[15:8] % div_values[7:0]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input int max, output int n, output int pulses, output logic [15:0] dv_last);
        n = 0;
        pulses = 0;
        dv_last = '0;
        while (n < max) begin
            @(negedge clk);
            n++;
            if (div_req) pulses++;
            if (ack_o != 4'b0000) break;
            dv_last = div_values;
        end
    endtask

    int          n, pulses;
    logic [15:0] dv_last;
    logic [15:0] rr_exp [4];

    initial begin
        rr_exp[0] = 16'h0301;
        rr_exp[1] = 16'h0302;
        rr_exp[2] = 16'h0400;
        rr_exp[3] = 16'h0401;
        reset = 1'b1;
        req_i = 4'b0000;
        values_i = '0;
        lat = 10;
        never_ack = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ack", ack_o, 4'b0000);
        chk("rst_result", result_o, 16'h0000);
        chk("rst_err", err_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_div_req", div_req, 1'b0);
        chk("rst_div_values", div_values, 16'h0000);
        chk("rst_div_reset_n", div_reset_n, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("rel_div_reset_n", div_reset_n, 1'b1);

        // 100/7 on requester 1 with a 10-cycle divider
        values_i[31:16] = 16'h6407;
        req_i = 4'b0010;
        @(negedge clk);
        chk("n_issue_div_req", div_req, 1'b1);
        chk("n_issue_busy", busy_o, 1'b1);
        chk("n_issue_values", div_values, 16'h6407);
        values_i[31:16] = 16'h0101;
        wait_ack(200, n, pulses, dv_last);
        chk("n_latency", n + 1, 13);
        chk("n_extra_div_req", pulses, 0);
        chk("n_ack", ack_o, 4'b0010);
        chk("n_result", result_o, 16'h0E02);
        chk("n_err", err_o, 1'b0);
        chk("n_values_held", dv_last, 16'h6407);
        req_i = 4'b0000;
        @(negedge clk);
        chk("n_ack_pulse", ack_o, 4'b0000);
        chk("n_idle", busy_o, 1'b0);

        // Divide by zero on requester 2
        values_i[47:32] = 16'h2A00;
        req_i = 4'b0100;
        wait_ack(20, n, pulses, dv_last);
        chk("z_latency", n, 1);
        chk("z_div_req", pulses, 0);
        chk("z_ack", ack_o, 4'b0100);
        chk("z_result", result_o, 16'hFF2A);
        chk("z_err", err_o, 1'b1);
        req_i = 4'b0000;
        @(negedge clk);

        // Two full round-robin rounds from reset
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        lat = 2;
        for (int k = 0; k < 4; k++) values_i[16*k +: 16] = {8'(10 + k), 8'd3};
        for (int r = 0; r < 2; r++) begin
            req_i = 4'b1111;
            for (int k = 0; k < 4; k++) begin
                wait_ack(50, n, pulses, dv_last);
                chk($sformatf("rr%0d_ack%0d", r, k), ack_o, 4'b0001 << k);
                chk($sformatf("rr%0d_res%0d", r, k), result_o, rr_exp[k]);
                req_i = req_i & ~ack_o;
                @(negedge clk);
            end
        end

        // Timeout: divider never acks
        never_ack = 1'b1;
        values_i[15:0] = 16'h0503;
        req_i = 4'b0001;
        wait_ack(200, n, pulses, dv_last);
        chk("t_latency", n, 67);
        chk("t_div_req", pulses, 1);
        chk("t_ack", ack_o, 4'b0001);
        chk("t_result", result_o, 16'h0000);
        chk("t_err", err_o, 1'b1);
        chk("t_div_reset_n", div_reset_n, 1'b0);
        req_i = 4'b0000;
        @(negedge clk);
        chk("t_div_reset_n_after", div_reset_n, 1'b1);
        chk("t_idle", busy_o, 1'b0);

        // Reset during WAIT, then requester 0 wins over 3
        values_i[15:0]  = 16'h0A02;
        values_i[63:48] = 16'h0B02;
        req_i = 4'b1001;
        repeat (5) @(negedge clk);
        chk("w_busy", busy_o, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("w_rst_busy", busy_o, 1'b0);
        chk("w_rst_ack", ack_o, 4'b0000);
        chk("w_rst_result", result_o, 16'h0000);
        chk("w_rst_err", err_o, 1'b0);
        chk("w_rst_div_req", div_req, 1'b0);
        chk("w_rst_div_values", div_values, 16'h0000);
        chk("w_rst_div_reset_n", div_reset_n, 1'b0);
        reset = 1'b0;
        never_ack = 1'b0;
        wait_ack(50, n, pulses, dv_last);
        chk("w_first_ack", ack_o, 4'b0001);
        chk("w_first_result", result_o, 16'h0500);
        req_i = 4'b1000;
        @(negedge clk);
        wait_ack(50, n, pulses, dv_last);
        chk("w_second_ack", ack_o, 4'b1000);
        chk("w_second_result", result_o, 16'h0501);
        req_i = 4'b0000;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
